// File: rtl/jk_counter_bank.sv
`default_nettype none
// ============================================================================
// Module   : jk_counter_bank
// Purpose  : Bank of WIDTH JK flip-flop stages. The stages are driven either
//            by external J/K inputs or by internal toggle enables, so the
//            bank can work as an up counter or a down counter. A registered
//            one-cycle wrap pulse flags counting overflow and underflow.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   WIDTH           : number of JK stages (2..16)
// Ports
//   input_clock     : in  1     rising-edge clock
//   input_reset     : in  1     synchronous active-high reset
//   input_enable    : in  1     0 = hold all stages
//   input_clear     : in  1     synchronous clear (overrides enable)
//   input_mode      : in  2     00 ext JK, 01 up, 10 down, 11 hold
//   input_j         : in  WIDTH per-stage J (mode 00 only)
//   input_k         : in  WIDTH per-stage K (mode 00 only)
//   output_led_q    : out WIDTH stage Q values
//   output_led_qn   : out WIDTH complement of output_led_q
//   output_led_wrap : out 1     pulse in the cycle after a counting wrap
// ============================================================================
module jk_counter_bank #(
    parameter int WIDTH = 4
) (
    input  logic             input_clock,
    input  logic             input_reset,
    input  logic             input_enable,
    input  logic             input_clear,
    input  logic [1:0]       input_mode,
    input  logic [WIDTH-1:0] input_j,
    input  logic [WIDTH-1:0] input_k,
    output logic [WIDTH-1:0] output_led_q,
    output logic [WIDTH-1:0] output_led_qn,
    output logic             output_led_wrap
);

    localparam logic [1:0] c_MODE_JK   = 2'b00;
    localparam logic [1:0] c_MODE_UP   = 2'b01;
    localparam logic [1:0] c_MODE_DOWN = 2'b10;
    localparam logic [1:0] c_MODE_HOLD = 2'b11;

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic             wrap_q;
    logic             wrap_d;

    // Per-stage toggle enables for ripple-free counting: a stage toggles when
    // every lower stage is 1 (up) or every lower stage is 0 (down).
    logic [WIDTH-1:0] w_up_tgl;
    logic [WIDTH-1:0] w_dn_tgl;
    logic [WIDTH-1:0] w_jk_next;

    assign w_up_tgl[0] = 1'b1;
    assign w_dn_tgl[0] = 1'b1;

    for (genvar i = 1; i < WIDTH; i++) begin : g_stage
        assign w_up_tgl[i] = w_up_tgl[i-1] &  q_q[i-1];
        assign w_dn_tgl[i] = w_dn_tgl[i-1] & ~q_q[i-1];
    end

    // Characteristic JK equation: Q+ = J&~Q | ~K&Q
    assign w_jk_next = (input_j & ~q_q) | (~input_k & q_q);

    // The top stage's toggle enable combined with its own value tells us the
    // whole bank is all-ones (up) or all-zeros (down), i.e. the edge wraps.
    always_comb begin
        q_d    = q_q;
        wrap_d = 1'b0;
        if (input_clear) begin
            q_d = '0;
        end else if (input_enable) begin
            case (input_mode)
                c_MODE_JK: begin
                    q_d = w_jk_next;
                end
                c_MODE_UP: begin
                    q_d    = q_q ^ w_up_tgl;
                    wrap_d = w_up_tgl[WIDTH-1] & q_q[WIDTH-1];
                end
                c_MODE_DOWN: begin
                    q_d    = q_q ^ w_dn_tgl;
                    wrap_d = w_dn_tgl[WIDTH-1] & ~q_q[WIDTH-1];
                end
                c_MODE_HOLD: begin
                    q_d = q_q;
                end
                default: begin
                    q_d = q_q;
                end
            endcase
        end
    end

    always_ff @(posedge input_clock) begin
        if (input_reset) begin
            q_q    <= '0;
            wrap_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            wrap_q <= wrap_d;
        end
    end

    assign output_led_q    = q_q;
    assign output_led_qn   = ~q_q;
    assign output_led_wrap = wrap_q;

endmodule
`default_nettype wire

// File: tb/tb_jk_counter_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_jk_counter_bank
// Purpose  : Directed self-checking bench for jk_counter_bank. Drives a
//            4-stage instance through counting, JK, enable, clear, reset and
//            mode-switch cases, then an 8-stage instance through a full
//            count cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jk_counter_bank;

    logic       clk;
    logic       rst;
    logic       en;
    logic       clr;
    logic [1:0] mode;
    logic [3:0] j;
    logic [3:0] k;
    logic [3:0] q;
    logic [3:0] qn;
    logic       wrap;

    logic [7:0] j8;
    logic [7:0] k8;
    logic [7:0] q8;
    logic [7:0] qn8;
    logic       wrap8;

    int nvec;
    int nerr;

    jk_counter_bank #(.WIDTH(4)) dut (
        .input_clock     (clk),
        .input_reset     (rst),
        .input_enable    (en),
        .input_clear     (clr),
        .input_mode      (mode),
        .input_j         (j),
        .input_k         (k),
        .output_led_q    (q),
        .output_led_qn   (qn),
        .output_led_wrap (wrap)
    );

    jk_counter_bank #(.WIDTH(8)) dut8 (
        .input_clock     (clk),
        .input_reset     (rst),
        .input_enable    (en),
        .input_clear     (clr),
        .input_mode      (mode),
        .input_j         (j8),
        .input_k         (k8),
        .output_led_q    (q8),
        .output_led_qn   (qn8),
        .output_led_wrap (wrap8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle past it before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        nvec++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Check the 4-stage outputs as a group.
    task automatic chk4(input string tag, input logic [3:0] eq, input logic ew);
        chk({tag, ".q"}, {12'h0, q}, {12'h0, eq});
        chk({tag, ".qn"}, {12'h0, qn}, {12'h0, ~eq});
        chk({tag, ".wrap"}, {15'h0, wrap}, {15'h0, ew});
    endtask

    initial begin
        logic [3:0] eq;
        logic [7:0] eq8;
        logic       ew;
        nvec = 0;
        nerr = 0;
        rst  = 1'b1;
        en   = 1'b0;
        clr  = 1'b0;
        mode = 2'b01;
        j    = 4'h0;
        k    = 4'h0;
        j8   = 8'h00;
        k8   = 8'h00;

        // Reset for two cycles
        step();
        step();
        chk4("reset", 4'h0, 1'b0);

        // Count up 17 edges: 1..15,0,1 with wrap after 15->0 only
        rst = 1'b0;
        en  = 1'b1;
        eq  = 4'h0;
        for (int n = 0; n < 17; n++) begin
            ew = (eq == 4'hF);
            eq = eq + 4'h1;
            step();
            chk4($sformatf("up%0d", n), eq, ew);
        end

        // Clear, then one down edge from 0 underflows
        clr = 1'b1;
        step();
        chk4("clr0", 4'h0, 1'b0);
        clr  = 1'b0;
        mode = 2'b10;
        step();
        chk4("down_wrap", 4'hF, 1'b1);
        mode = 2'b11;
        j    = 4'hF;
        k    = 4'h0;
        step();
        chk4("hold", 4'hF, 1'b0);

        // External JK: load 0011, then set/clear/toggle/hold mix, then toggle all
        mode = 2'b00;
        j    = 4'b0011;
        k    = 4'b1100;
        step();
        chk4("jk_load", 4'b0011, 1'b0);
        j = 4'b1010;
        k = 4'b0110;
        step();
        chk4("jk_mix", 4'b1001, 1'b0);
        j = 4'b1111;
        k = 4'b1111;
        step();
        chk4("jk_tgl", 4'b0110, 1'b0);
        // JK-driven all-ones -> zero must not pulse wrap
        j = 4'hF;
        k = 4'h0;
        step();
        chk4("jk_set", 4'hF, 1'b0);
        j = 4'h0;
        k = 4'hF;
        step();
        chk4("jk_clrnw", 4'h0, 1'b0);

        // Enable low at 7 for three edges, then resume counting to 8
        j = 4'b0111;
        k = 4'b1000;
        step();
        chk4("load7", 4'h7, 1'b0);
        mode = 2'b01;
        en   = 1'b0;
        for (int n = 0; n < 3; n++) begin
            step();
            chk4($sformatf("dis%0d", n), 4'h7, 1'b0);
        end
        en = 1'b1;
        step();
        chk4("reen", 4'h8, 1'b0);

        // Disabled at 15 in up mode: no count, no wrap
        mode = 2'b00;
        j    = 4'hF;
        k    = 4'h0;
        step();
        mode = 2'b01;
        en   = 1'b0;
        step();
        chk4("dis15", 4'hF, 1'b0);

        // Clear at 15 in up mode beats the wrap
        en  = 1'b1;
        clr = 1'b1;
        step();
        chk4("clr15", 4'h0, 1'b0);

        // Clear works even with enable low
        clr = 1'b0;
        step();
        step();
        chk4("pre_clr_dis", 4'h2, 1'b0);
        en  = 1'b0;
        clr = 1'b1;
        step();
        chk4("clr_dis", 4'h0, 1'b0);

        // Reset at 15 in up mode beats the wrap, then counting resumes from 0
        clr  = 1'b0;
        en   = 1'b1;
        mode = 2'b00;
        step();
        chk4("load15", 4'hF, 1'b0);
        mode = 2'b01;
        rst  = 1'b1;
        step();
        chk4("rst15", 4'h0, 1'b0);
        rst = 1'b0;
        step();
        chk4("post_rst", 4'h1, 1'b0);

        // Switch up -> down at 0 wraps on that edge; then up wraps back
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk4("clr_sw", 4'h0, 1'b0);
        mode = 2'b10;
        step();
        chk4("sw_down", 4'hF, 1'b1);
        mode = 2'b01;
        step();
        chk4("sw_up", 4'h0, 1'b1);
        step();
        chk4("sw_up2", 4'h1, 1'b0);

        // 8-stage instance: full cycle, wrap only after 255->0
        rst = 1'b1;
        step();
        step();
        chk("w8.rst", {8'h0, q8}, 16'h0000);
        rst = 1'b0;
        eq8 = 8'h00;
        for (int n = 0; n < 257; n++) begin
            ew  = (eq8 == 8'hFF);
            eq8 = eq8 + 8'h01;
            step();
            if (ew || n == 256 || n == 0 || n == 100) begin
                chk($sformatf("w8.q%0d", n), {8'h0, q8}, {8'h0, eq8});
                chk($sformatf("w8.qn%0d", n), {8'h0, qn8}, {8'h0, ~eq8});
            end
            chk($sformatf("w8.wrap%0d", n), {15'h0, wrap8}, {15'h0, ew});
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
`default_nettype wire
